// File: rtl/mem32_pkg.sv
// Shared definitions for the mem32 word reader.
// Contents:
//   MEM_ADDR_W / MEM_BYTE_W / MEM_NBYTES : geometry of the mem32 byte store
//   MEM_WORD_W / MEM_LANE_W               : derived word width and lane-index width
//   state_e                               : sequencer state encoding
//   lane_lsb()                            : lane index -> LSB of its byte slice in the word
package mem32_pkg;

    localparam int MEM_ADDR_W = 4;
    localparam int MEM_BYTE_W = 8;
    localparam int MEM_NBYTES = 4;
    localparam int MEM_WORD_W = MEM_NBYTES * MEM_BYTE_W;
    localparam int MEM_LANE_W = (MEM_NBYTES > 1) ? $clog2(MEM_NBYTES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Lane 0 (lowest byte address) lands in the most significant byte.
    function automatic int lane_lsb(input int lane, input int nbytes, input int byte_w);
        return (nbytes - 1 - lane) * byte_w;
    endfunction

endpackage

// File: rtl/mem32_word_reader_if.sv
// Request/response port of the mem32 word reader.
// Signals:
//   req_valid / req_ready / req_addr            : word-read request handshake
//   resp_valid / resp_ready / resp_data / resp_err : response handshake
// Modports:
//   master : the consumer issuing requests
//   slave  : the word reader
interface mem32_word_reader_if
    import mem32_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int WORD_W = MEM_WORD_W
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [WORD_W-1:0] resp_data;
    logic              resp_err;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/mem32_lat_pipe.sv
// Read-latency tracker: an RD_LAT-deep shift register of {valid, lane index}
// that travels alongside each byte read issued into mem32, so the packer knows
// exactly when mem_dout carries a byte and which lane it belongs to.
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous active-low reset (clears every stage)
//   valid_i : a byte read was accepted by mem32 on this edge
//   lane_i  : lane index of that read
//   valid_o : mem_dout holds the byte for lane_o this cycle
//   lane_o  : lane index of the arriving byte
module mem32_lat_pipe
    import mem32_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int LANE_W = MEM_LANE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [LANE_W-1:0] lane_i,
    output logic              valid_o,
    output logic [LANE_W-1:0] lane_o
);

    generate
        for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
            logic              valid_q;
            logic [LANE_W-1:0] lane_q;
            logic              valid_d;
            logic [LANE_W-1:0] lane_d;

            if (gi == 0) begin : g_head
                assign valid_d = valid_i;
                assign lane_d  = lane_i;
            end else begin : g_tail
                assign valid_d = g_stage[gi-1].valid_q;
                assign lane_d  = g_stage[gi-1].lane_q;
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid_q <= 1'b0;
                    lane_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    lane_q  <= lane_d;
                end
            end
        end
    endgenerate

    assign valid_o = g_stage[RD_LAT-1].valid_q;
    assign lane_o  = g_stage[RD_LAT-1].lane_q;

endmodule

// File: rtl/mem32_word_reader.sv
// Word-read sequencer in front of the 16-byte mem32 store. Accepts one aligned
// word request, issues NBYTES byte reads into mem32, packs the returned bytes
// (lowest address in the top byte) and returns the word on a valid/ready port.
// Misaligned requests are answered immediately with resp_err=1 and zero data.
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   bus       : request/response port (slave side)
//   mem_rd    : byte read strobe into mem32 (registered)
//   mem_addr  : byte address into mem32 (registered)
//   mem_dout  : mem32 read data, valid RD_LAT cycles after a strobe is taken
//   mem_busy  : mem32 busy; a high sample suppresses the strobe for the next cycle
module mem32_word_reader
    import mem32_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int BYTE_W = MEM_BYTE_W,
    parameter int NBYTES = MEM_NBYTES,
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    mem32_word_reader_if.slave bus,
    output logic               mem_rd,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [BYTE_W-1:0]  mem_dout,
    input  logic               mem_busy
);

    localparam int WORD_W = NBYTES * BYTE_W;
    localparam int LANE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(NBYTES - 1);
    localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(NBYTES - 1);

    state_e              state_q, state_d;
    logic [LANE_W-1:0]   k_q, k_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   pack_q, pack_d;
    logic                resp_valid_q, resp_valid_d;
    logic [WORD_W-1:0]   resp_data_q, resp_data_d;
    logic                resp_err_q, resp_err_d;

    logic                issue;
    logic                cap_valid;
    logic [LANE_W-1:0]   cap_lane;
    logic [WORD_W-1:0]   cap_word;

    // A byte read is taken by mem32 on every edge where the strobe is up.
    assign issue = (state_q == ST_ISSUE) && mem_rd_q;

    mem32_lat_pipe #(
        .RD_LAT (RD_LAT),
        .LANE_W (LANE_W)
    ) u_lat_pipe (
        .clk     (clk),
        .rst     (rst),
        .valid_i (issue),
        .lane_i  (k_q),
        .valid_o (cap_valid),
        .lane_o  (cap_lane)
    );

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        base_d       = base_q;
        mem_rd_d     = mem_rd_q;
        mem_addr_d   = mem_addr_q;
        pack_d       = pack_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;

        // Pack register with the arriving byte merged into its lane.
        cap_word = pack_q;
        cap_word[lane_lsb(int'(cap_lane), NBYTES, BYTE_W) +: BYTE_W] = mem_dout;
        if (cap_valid) begin
            pack_d = cap_word;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    base_d = bus.req_addr;
                    if ((bus.req_addr & ALIGN_MASK) != '0) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_data_d  = '0;
                    end else begin
                        // mem_busy is not consulted here: the first strobe
                        // always goes out the cycle after the handshake.
                        state_d    = ST_ISSUE;
                        k_d        = '0;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = bus.req_addr;
                        pack_d     = '0;
                    end
                end
            end

            ST_ISSUE: begin
                // Busy sampled now gates the strobe presented next cycle;
                // the address only advances once its byte has been taken.
                mem_rd_d = !mem_busy;
                if (issue) begin
                    if (k_q == LAST_LANE) begin
                        state_d  = ST_DRAIN;
                        mem_rd_d = 1'b0;
                    end else begin
                        k_d        = k_q + 1'b1;
                        mem_addr_d = base_q + ADDR_W'(k_q) + ADDR_W'(1);
                    end
                end
            end

            ST_DRAIN: begin
                // Bytes return in issue order, so the last lane closes the word.
                if (cap_valid && (cap_lane == LAST_LANE)) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_data_d  = cap_word;
                    resp_err_d   = 1'b0;
                end
            end

            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            base_q       <= '0;
            mem_rd_q     <= 1'b0;
            mem_addr_q   <= '0;
            pack_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            base_q       <= base_d;
            mem_rd_q     <= mem_rd_d;
            mem_addr_q   <= mem_addr_d;
            pack_q       <= pack_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
    assign mem_rd         = mem_rd_q;
    assign mem_addr       = mem_addr_q;

endmodule
